// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the game sequencer and the rest of the Flappy Bird
// design: button pulses, the bird/pipe geometry, and the game status outputs.
interface flappy_game_ctrl_if;
    logic               frame_tick;
    logic               start_btn;
    logic               pause_btn;
    logic               jump_btn;
    logic signed [10:0] bird_y;
    logic signed [10:0] pipe_x;
    logic        [10:0] gap_top;
    logic        [10:0] gap_bot;
    logic        [1:0]  status;
    logic               pause;
    logic               jump;
    logic        [9:0]  score;
    logic        [9:0]  high_score;
    logic               game_over;

    modport master (
        output frame_tick, start_btn, pause_btn, jump_btn,
        output bird_y, pipe_x, gap_top, gap_bot,
        input  status, pause, jump, score, high_score, game_over
    );

    modport slave (
        input  frame_tick, start_btn, pause_btn, jump_btn,
        input  bird_y, pipe_x, gap_top, gap_bot,
        output status, pause, jump, score, high_score, game_over
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: IDLE -> READY -> PLAY -> OVER, with pause,
// gated jump, collision detection, scoring and a high-score register.
module flappy_game_ctrl #(
    parameter int BIRD_X       = 100,
    parameter int BIRD_W       = 20,
    parameter int BIRD_H       = 20,
    parameter int PIPE_W       = 60,
    parameter int FLOOR_Y      = 445,
    parameter int READY_FRAMES = 60
) (
    input logic               clk,
    input logic               rst,
    flappy_game_ctrl_if.slave bus
);
    localparam int CW = $clog2(READY_FRAMES + 1);

    // Geometry constants in the 12-bit signed domain used for every compare.
    localparam logic signed [11:0] BX = 12'(BIRD_X);
    localparam logic signed [11:0] BW = 12'(BIRD_W);
    localparam logic signed [11:0] BH = 12'(BIRD_H);
    localparam logic signed [11:0] PW = 12'(PIPE_W);
    localparam logic signed [11:0] FY = 12'(FLOOR_Y);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            pause_q, pause_d;
    logic            jump_q, jump_d;
    logic            go_q, go_d;
    logic            passed_q, passed_d;
    logic [9:0]      score_q, score_d;
    logic [9:0]      high_q, high_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic signed [11:0] by, px, gt, gb;
    logic               tick_live, hit_ground, hit_pipe, crossed, wrapped;

    // Sign/zero-extend geometry and evaluate collision and scoring conditions.
    always_comb begin
        by         = {bus.bird_y[10], bus.bird_y};
        px         = {bus.pipe_x[10], bus.pipe_x};
        gt         = {1'b0, bus.gap_top};
        gb         = {1'b0, bus.gap_bot};
        tick_live  = bus.frame_tick && !pause_q;
        hit_ground = by >= FY;
        hit_pipe   = (px < BX + BW) && (px + PW > BX) &&
                     ((by < gt) || (by + BH > gb));
        crossed    = (px + PW) < BX;
        wrapped    = px > (BX + BW);
    end

    // Next-state and next-output logic for the game sequencer.
    always_comb begin
        state_d  = state_q;
        pause_d  = pause_q;
        score_d  = score_q;
        high_d   = high_q;
        cnt_d    = cnt_q;
        passed_d = passed_q;
        go_d     = 1'b0;
        jump_d   = bus.jump_btn && (state_q == S_PLAY) && !pause_q;

        unique case (state_q)
            S_IDLE: begin
                score_d  = '0;
                cnt_d    = '0;
                passed_d = 1'b0;
                if (bus.start_btn) state_d = S_READY;
            end
            S_READY: begin
                if (bus.frame_tick) begin
                    if (cnt_q == CW'(READY_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                // A hit pre-empts both the pause toggle and scoring on the same cycle.
                if (tick_live && (hit_ground || hit_pipe)) begin
                    state_d = S_OVER;
                    go_d    = 1'b1;
                    if (score_q > high_q) high_d = score_q;
                end else begin
                    if (bus.pause_btn) pause_d = !pause_q;
                    if (tick_live) begin
                        if (crossed && !passed_q) begin
                            if (score_q != '1) score_d = score_q + 10'd1;
                            passed_d = 1'b1;
                        end else if (wrapped) begin
                            passed_d = 1'b0;
                        end
                    end
                end
            end
            S_OVER: begin
                cnt_d = '0;
                if (bus.start_btn) begin
                    state_d  = S_READY;
                    score_d  = '0;
                    passed_d = 1'b0;
                end
            end
        endcase

        if (state_d != S_PLAY) pause_d = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pause_q  <= 1'b0;
            jump_q   <= 1'b0;
            go_q     <= 1'b0;
            passed_q <= 1'b0;
            score_q  <= '0;
            high_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pause_q  <= pause_d;
            jump_q   <= jump_d;
            go_q     <= go_d;
            passed_q <= passed_d;
            score_q  <= score_d;
            high_q   <= high_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.status     = state_q;
    assign bus.pause      = pause_q;
    assign bus.jump       = jump_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.game_over  = go_q;
endmodule
